// File: rtl/multiplier_appr.sv
`default_nettype none
// ============================================================================
// multiplier_appr : signed 16x16 radix-4 Booth multiplier, low columns truncated
// Rev 1.0
// ============================================================================
module multiplier_appr #(
  parameter int                 VBL  = 8,
  parameter logic signed [31:0] COMP = 32'sd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] A,
  input  logic signed [15:0] B,
  input  logic               in_vld,
  output logic signed [31:0] out,
  output logic               out_vld
);

  localparam logic [31:0] c_MASK = ~((32'd1 << VBL) - 32'd1);

  logic [16:0] w_bx;
  logic [31:0] w_a1;
  logic [31:0] w_a2;
  logic [31:0] w_pp [8];
  logic [31:0] w_sum;

  // b[-1] = 0 is the appended LSB of the recoding window
  assign w_bx = {B, 1'b0};
  assign w_a1 = {{16{A[15]}}, A};
  assign w_a2 = {w_a1[30:0], 1'b0};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pp
      logic [2:0]  w_trip;
      logic [31:0] w_sel;

      assign w_trip = w_bx[2*gi+2 : 2*gi];

      // full two's-complement negation happens before the column mask
      always_comb begin
        w_sel = 32'd0;
        case (w_trip)
          3'b001, 3'b010: w_sel = w_a1;
          3'b011:         w_sel = w_a2;
          3'b100:         w_sel = 32'd0 - w_a2;
          3'b101, 3'b110: w_sel = 32'd0 - w_a1;
          default:        w_sel = 32'd0;
        endcase
      end

      assign w_pp[gi] = (w_sel << (2 * gi)) & c_MASK;
    end
  endgenerate

  always_comb begin
    w_sum = COMP;
    for (int i = 0; i < 8; i++) begin
      w_sum = w_sum + w_pp[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out     <= 32'sd0;
      out_vld <= 1'b0;
    end else begin
      out     <= w_sum;
      out_vld <= in_vld;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiplier_appr.sv
`default_nettype none
// ============================================================================
// tb_multiplier_appr : directed and bounded-random checks of multiplier_appr
// Rev 1.0
// ============================================================================
module tb_multiplier_appr;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] A;
  logic signed [15:0] B;
  logic               in_vld;
  logic signed [31:0] out_d;
  logic               vld_d;
  logic signed [31:0] out_x;
  logic               vld_x;
  logic signed [31:0] out_c;
  logic               vld_c;

  int n_cmp = 0;
  int n_err = 0;

  multiplier_appr u_dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_vld(in_vld),
    .out(out_d), .out_vld(vld_d)
  );

  multiplier_appr #(.VBL(0), .COMP(32'sd0)) u_exact (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_vld(in_vld),
    .out(out_x), .out_vld(vld_x)
  );

  multiplier_appr #(.VBL(8), .COMP(32'sd100)) u_comp (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_vld(in_vld),
    .out(out_c), .out_vld(vld_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [15:0] a, input logic signed [15:0] b, input logic v);
    A      = a;
    B      = b;
    in_vld = v;
  endtask

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [31:0] exp;
  } vec_t;

  vec_t dir [5];
  logic signed [15:0] corner [5];
  logic               pat [5];
  logic signed [15:0] pa [5];
  logic signed [15:0] pb [5];

  initial begin
    int  p;
    int  diff;
    real sum;
    real sumsq;
    real mean;
    int  nrnd;

    rst_n = 1'b0;
    drive(16'sd1234, 16'sd567, 1'b1);

    // reset held two edges with live inputs
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_out", out_d, 32'd0);
      check_eq("rst_vld", {31'd0, vld_d}, 32'd0);
    end
    rst_n = 1'b1;
    step();
    check_eq("post_rst_out", out_d, 32'sd699136);
    check_eq("post_rst_vld", {31'd0, vld_d}, 32'd1);
    check_eq("post_rst_exact", out_x, 32'sd699678);

    // hand-computed directed vectors for VBL=8, COMP=0
    dir[0] = '{16'sd256,    16'sd4,      32'sd1024};
    dir[1] = '{-16'sd32768, -16'sd32768, 32'sd1073741824};
    dir[2] = '{16'sd0,      -16'sd1,     32'sd0};
    dir[3] = '{-16'sd1,     -16'sd1,     32'sd0};
    dir[4] = '{16'sd100,    16'sd3,      32'sd0};
    for (int i = 0; i < 5; i++) begin
      drive(dir[i].a, dir[i].b, 1'b1);
      step();
      check_eq($sformatf("dir%0d", i), out_d, dir[i].exp);
      check_eq($sformatf("dir%0d_comp", i), out_c, dir[i].exp + 32'sd100);
    end

    // corner pairs against the exact instance
    corner[0] = 16'sd0;
    corner[1] = 16'sd1;
    corner[2] = -16'sd1;
    corner[3] = 16'sd32767;
    corner[4] = -16'sd32768;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        drive(corner[i], corner[j], 1'b1);
        step();
        p = corner[i] * corner[j];
        check_eq($sformatf("corner_%0d_%0d", i, j), out_x, p);
      end
    end

    // random exactness with VBL=0
    for (int i = 0; i < 2000; i++) begin
      drive(16'($urandom), 16'($urandom), 1'b1);
      step();
      p = A * B;
      check_eq("rand_exact", out_x, p);
    end

    // error bound with a fixed filter coefficient
    sum   = 0.0;
    sumsq = 0.0;
    nrnd  = 2000;
    for (int i = 0; i < nrnd; i++) begin
      drive(16'($urandom), -16'sd276, 1'b1);
      step();
      p    = A * B;
      diff = p - out_d;
      check_eq("err_bound", {31'd0, (diff >= 0 && diff < 2048)}, 32'd1);
      check_eq("low_bits_zero", {24'd0, out_d[7:0]}, 32'd0);
      sum   = sum + real'(-diff);
      sumsq = sumsq + real'(diff) * real'(diff);
    end
    mean = sum / real'(nrnd);
    $display("error stats (out - A*B): mean %f  stddev %f", mean,
             $sqrt(sumsq / real'(nrnd) - mean * mean));

    // in_vld pattern with a new operand pair every cycle
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
    pa[0] = 16'sd256;  pb[0] = 16'sd4;
    pa[1] = 16'sd1024; pb[1] = 16'sd2;
    pa[2] = -16'sd512; pb[2] = 16'sd8;
    pa[3] = 16'sd768;  pb[3] = -16'sd1;
    pa[4] = 16'sd0;    pb[4] = 16'sd77;
    for (int i = 0; i < 5; i++) begin
      drive(pa[i], pb[i], pat[i]);
      step();
      p = pa[i] * pb[i];
      check_eq($sformatf("tp%0d_vld", i), {31'd0, vld_d}, {31'd0, pat[i]});
      check_eq($sformatf("tp%0d_out", i), out_d, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiplier_appr.md
# multiplier_appr

Signed 16x16 approximate multiplier using radix-4 Booth recoding with broken-array truncation of low-order partial-product columns. It trades accuracy in the low result bits for reduced adder-tree area. Used in datapaths, such as fixed-point filter coefficient multiplies, where the caller arithmetic-shifts the 32-bit result right by its fractional width and tolerates small bounded error. Output is registered, with a one-cycle latency.

## Interface
- VBL, default 8: vertical breaking level. Partial-product bits in columns [VBL-1:0] are discarded. Legal range 0..16; 0 gives an exact multiplier.
- COMP, default 0: 32-bit signed compensation constant added to the truncated sum.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset (sampled on rising edge of clk).
- A  input  16  signed multiplicand (two's complement).
- B  input  16  signed multiplier (two's complement), Booth-recoded.
- in_vld  input  1  A/B valid this cycle.
- out  output  32  signed approximate product, registered.
- out_vld  output  1  out holds the result of a valid input from the previous cycle.

## Operation
- Booth recoding of B:
  - Set b[-1]=0.
  - For i=0..7, the digit d_i = -2*b[2i+1] + b[2i] + b[2i-1], with d_i in {-2,-1,0,+1,+2}.
- Partial products:
  - PP_i = d_i * A * 4^i, evaluated exactly as a 32-bit two's-complement value.
  - Sign extension is to full 32 bits.
  - Negation is a true negation (the ~X+1 carry is included before truncation).
- Truncation:
  - Each PP_i has bits [VBL-1:0] forced to 0 before summation.
  - No carries from the discarded columns are propagated.
- Result: out_next = (sum over i=0..7 of truncated PP_i + COMP) mod 2^32, interpreted as signed.
- With VBL=0 and COMP=0, out_next equals A*B exactly for all inputs, including A=B=-32768, which gives +2^30.
- Error properties with COMP=0:
  - out_next <= A*B.
  - A*B - out_next < 8*2^VBL.
  - The low VBL bits of out_next are always 0.
- The internal summation structure is free (Wallace, Dadda, or a carry-save array followed by a final CPA). Only the arithmetic definition above is normative.
- No overflow is possible: |A*B| <= 2^30, and truncation reduces the magnitude by less than 2^(VBL+3).

## Timing
- One register stage: A/B sampled at rising edge N produce out at N+1.
  - out_vld at N+1 equals in_vld at N.
- out and out_vld update on every clock edge regardless of in_vld.
  - out reflects A/B of the previous cycle even when in_vld=0.
  - Consumers qualify out with out_vld.
- Reset: when rst_n=0 at a rising edge, out<=0 and out_vld<=0 on that edge, overriding any input.
  - First valid output is the cycle after the first edge with rst_n=1 and in_vld=1.
- Reset asserted mid-stream discards the in-flight result; there is no recovery of that operand pair.
- Back-to-back inputs are accepted every cycle: full throughput, no stall or backpressure.
- Combinational path from A/B to the out register must close timing in one cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with A=1234, B=567, in_vld=1 -> out=0 and out_vld=0 throughout.
  - Release reset -> next cycle out=(approximate 1234*567), out_vld=1.
- Exact cases, defaults VBL=8, COMP=0:
  - A=256, B=4 -> out=1024.
  - A=-32768, B=-32768 -> out=1073741824.
  - A=0, B=-1 -> out=0.
- Truncation cases, defaults:
  - A=-1, B=-1 -> out=0 (exact 1).
  - A=100, B=3 -> out=0 (exact 300: PP0=-256 after masking, PP1=+256).
- Exactness: VBL=0, COMP=0, 10^5 random signed pairs plus the corner values 0, +-1, 32767 and -32768 -> out equals A*B every time.
- Error bounds, defaults, 10^5 random A with fixed B=-276 (the value -0.0675 scaled by 2^12):
  - Every result satisfies 0 <= A*B-out < 2048.
  - The low 8 bits of out are always 0.
  - Report the mean and standard deviation of (out - A*B).
- Throughput and valid: toggle in_vld in the pattern 1,0,1,1,0 with new A/B every cycle -> out_vld reproduces the pattern delayed one cycle, and each out matches its own operand pair.
